// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Pipelined carry-lookahead adder/subtractor. A WIDTH-bit operation is split
//   into NSEG = WIDTH/SEG_W lookahead segments, and one segment is resolved per
//   stage. The carry between segments is registered, so no combinational path
//   spans more than one segment. The pipeline advances as one unit whenever
//   the output register is empty or is being drained.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake (in_ready = !out_valid | out_ready)
//   in_a, in_b            operands
//   in_cin                carry-in for add (ignored when in_sub=1)
//   in_sub                0: a+b+cin, 1: a-b (a + ~b + 1)
//   out_valid / out_ready result beat handshake
//   out_sum               result
//   out_cout              carry out of MSB (1 = no borrow when subtracting)
//   out_ovf               two's-complement overflow of the selected operation
module pipelined_cla_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int unsigned NSEG = WIDTH / SEG_W;

    logic en;
    logic cmsb_q;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // One lookahead segment: every carry is expanded from the g/p terms and the
    // segment carry-in directly. Returns {carry_out, sum}.
    function automatic logic [SEG_W:0] cla_seg(
        input logic [SEG_W-1:0] a,
        input logic [SEG_W-1:0] b,
        input logic             cin
    );
        logic [SEG_W-1:0] g;
        logic [SEG_W-1:0] p;
        logic [SEG_W:0]   c;
        logic             t;
        g = a & b;
        p = a ^ b;
        c = '0;
        for (int unsigned i = 0; i <= SEG_W; i++) begin
            t = cin;
            for (int unsigned j = 0; j < i; j++) t = t & p[j];
            c[i] = t;
            for (int unsigned j = 0; j < i; j++) begin
                t = g[j];
                for (int unsigned m = j + 1; m < i; m++) t = t & p[m];
                c[i] = c[i] | t;
            end
        end
        return {c[SEG_W], p ^ c[SEG_W-1:0]};
    endfunction

    for (genvar k = 0; k < NSEG; k++) begin : g_stg
        // Operand bits still unresolved on entry, and sum bits resolved on exit.
        localparam int unsigned RW = WIDTH - k * SEG_W;
        localparam int unsigned SW = (k + 1) * SEG_W;

        logic [RW-1:0]    a_d;
        logic [RW-1:0]    b_d;
        logic             cin_d;
        logic             vld_d;
        logic [SEG_W:0]   seg_res;
        logic [SW-1:0]    sum_d;
        logic [SW-1:0]    sum_q;
        logic             vld_q;
        logic             c_q;

        if (k == 0) begin : g_src
            // B is inverted here, so later stages only ever add.
            assign a_d   = in_a;
            assign b_d   = in_sub ? ~in_b : in_b;
            assign cin_d = in_sub | in_cin;
            assign vld_d = in_valid;
            assign sum_d = seg_res[SEG_W-1:0];
        end else begin : g_src
            assign a_d   = g_stg[k-1].g_fwd.a_q;
            assign b_d   = g_stg[k-1].g_fwd.b_q;
            assign cin_d = g_stg[k-1].c_q;
            assign vld_d = g_stg[k-1].vld_q;
            assign sum_d = {seg_res[SEG_W-1:0], g_stg[k-1].sum_q};
        end

        assign seg_res = cla_seg(a_d[SEG_W-1:0], b_d[SEG_W-1:0], cin_d);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (en) begin
                vld_q <= vld_d;
                c_q   <= seg_res[SEG_W];
                sum_q <= sum_d;
            end
        end

        // Only the operand bits of later segments travel on.
        if (k < NSEG - 1) begin : g_fwd
            logic [RW-SEG_W-1:0] a_q;
            logic [RW-SEG_W-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_d[RW-1:SEG_W];
                    b_q <= b_d[RW-1:SEG_W];
                end
            end
        end
    end

    // Carry into the MSB is recovered from sum ^ a ^ b at the top bit of the
    // last segment, and is registered alongside that stage's result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmsb_q <= 1'b0;
        end else if (en) begin
            cmsb_q <= g_stg[NSEG-1].seg_res[SEG_W-1]
                    ^ g_stg[NSEG-1].a_d[SEG_W-1]
                    ^ g_stg[NSEG-1].b_d[SEG_W-1];
        end
    end

    assign out_valid = g_stg[NSEG-1].vld_q;
    assign out_sum   = g_stg[NSEG-1].sum_q;
    assign out_cout  = g_stg[NSEG-1].c_q;
    assign out_ovf   = g_stg[NSEG-1].c_q ^ cmsb_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: a 32/8 instance for the main
// scenarios plus 16/4, 64/16 and 8/8 instances for the parameter sweep.
module tb_pipelined_cla_adder;
    localparam int unsigned W   = 32;
    localparam int          LAT = 4;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        int          e;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic         in_valid  = 1'b0;
    logic         in_cin    = 1'b0;
    logic         in_sub    = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] in_a      = '0;
    logic [W-1:0] in_b      = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_cout;
    logic         out_ovf;
    logic [W-1:0] out_sum;

    // Sweep instances share their inputs.
    logic        sw_valid = 1'b0;
    logic        sw_cin   = 1'b0;
    logic        sw_sub   = 1'b0;
    logic        sw_ordy  = 1'b1;
    logic [63:0] sw_a     = '0;
    logic [63:0] sw_b     = '0;
    logic        s0_rdy, s0_ov, s0_co, s0_of;
    logic        s1_rdy, s1_ov, s1_co, s1_of;
    logic        s2_rdy, s2_ov, s2_co, s2_of;
    logic [15:0] s0_sum;
    logic [63:0] s1_sum;
    logic [7:0]  s2_sum;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;
    beat_t q[$];
    beat_t sw_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    pipelined_cla_adder #(.WIDTH(32), .SEG_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf)
    );

    pipelined_cla_adder #(.WIDTH(16), .SEG_W(4)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s0_rdy),
        .in_a(sw_a[15:0]), .in_b(sw_b[15:0]), .in_cin(sw_cin), .in_sub(sw_sub),
        .out_valid(s0_ov), .out_ready(sw_ordy), .out_sum(s0_sum),
        .out_cout(s0_co), .out_ovf(s0_of)
    );

    pipelined_cla_adder #(.WIDTH(64), .SEG_W(16)) u_w64 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s1_rdy),
        .in_a(sw_a), .in_b(sw_b), .in_cin(sw_cin), .in_sub(sw_sub),
        .out_valid(s1_ov), .out_ready(sw_ordy), .out_sum(s1_sum),
        .out_cout(s1_co), .out_ovf(s1_of)
    );

    pipelined_cla_adder #(.WIDTH(8), .SEG_W(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s2_rdy),
        .in_a(sw_a[7:0]), .in_b(sw_b[7:0]), .in_cin(sw_cin), .in_sub(sw_sub),
        .out_valid(s2_ov), .out_ready(sw_ordy), .out_sum(s2_sum),
        .out_cout(s2_co), .out_ovf(s2_of)
    );

    // Reference: unsigned arithmetic for sum/carry, wide signed arithmetic for
    // overflow (result outside the representable w-bit signed range).
    function automatic res_t model(input logic [63:0] a_in, input logic [63:0] b_in,
                                   input logic cin, input logic sub, input int w);
        logic [63:0]        mask, a, b;
        logic [64:0]        u;
        logic [66:0]        ta, tb;
        logic signed [66:0] sa, sb, r, lim;
        res_t               res;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        if (sub) u = {1'b0, a} - {1'b0, b};
        else     u = {1'b0, a} + {1'b0, b} + {64'b0, cin};
        res.sum  = u[63:0] & mask;
        res.cout = sub ? (a >= b) : u[w];
        ta  = {3'b0, a} << (67 - w);
        tb  = {3'b0, b} << (67 - w);
        sa  = $signed(ta) >>> (67 - w);
        sb  = $signed(tb) >>> (67 - w);
        r   = sub ? (sa - sb) : (sa + sb + $signed({66'b0, cin}));
        lim = 67'sd1 <<< (w - 1);
        res.ovf = (r >= lim) || (r < -lim);
        return res;
    endfunction

    function automatic logic [63:0] rnd_op();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: v = '1;
            1: v = '0;
            2: v = 64'h0000_0000_7FFF_FFFF;
            3: v = 64'h0000_0000_8000_0000;
            default: ;
        endcase
        return v;
    endfunction

    task automatic drive_rand();
        logic [63:0] ra, rb;
        ra = rnd_op();
        rb = rnd_op();
        in_a   = ra[31:0];
        in_b   = rb[31:0];
        in_cin = 1'($urandom_range(0, 1));
        in_sub = 1'($urandom_range(0, 1));
    endtask

    task automatic push_main();
        beat_t b;
        b.a = {32'b0, in_a}; b.b = {32'b0, in_b};
        b.cin = in_cin; b.sub = in_sub; b.e = edge_cnt + 1;
        q.push_back(b);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_sum !== '0) begin failures++; $display("FAIL reset_sum: got %h expected 0", out_sum); end
        checks++; if (out_cout !== 1'b0) begin failures++; $display("FAIL reset_cout: got %b expected 0", out_cout); end
        checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", out_ovf); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [31:0] va[6], vb[6], vs[6];
        logic        vc[6], vsub[6], vco[6], vov[6];
        int          lat;
        va   = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0, 32'h8000_0000};
        vb   = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0007, 32'h0000_0001, 32'h0, 32'h8000_0000};
        vc   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vsub = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vs   = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h0, 32'h0};
        vco  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vov  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_a = va[i]; in_b = vb[i]; in_cin = vc[i]; in_sub = vsub[i]; in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 12) begin
                @(posedge clk);
                #1;
                lat++;
            end
            checks++; if (lat !== LAT) begin failures++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, LAT); end
            checks++; if (out_sum !== vs[i]) begin failures++; $display("FAIL dir%0d_sum: got %h expected %h", i, out_sum, vs[i]); end
            checks++; if (out_cout !== vco[i]) begin failures++; $display("FAIL dir%0d_cout: got %b expected %b", i, out_cout, vco[i]); end
            checks++; if (out_ovf !== vov[i]) begin failures++; $display("FAIL dir%0d_ovf: got %b expected %b", i, out_ovf, vov[i]); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stream();
        int    sent = 0;
        int    got  = 0;
        beat_t b;
        res_t  ex;
        out_ready = 1'b1;
        for (int c = 0; c < 200 && (sent < 100 || q.size() > 0); c++) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL stream_extra: got result %h expected none", out_sum);
                end else begin
                    b  = q.pop_front();
                    ex = model(b.a, b.b, b.cin, b.sub, W);
                    checks++;
                    if ({out_sum, out_cout, out_ovf} !== {ex.sum[W-1:0], ex.cout, ex.ovf}) begin
                        failures++;
                        $display("FAIL stream_data: got %h/%b/%b expected %h/%b/%b", out_sum, out_cout, out_ovf, ex.sum[W-1:0], ex.cout, ex.ovf);
                    end
                    checks++;
                    if (edge_cnt !== b.e + LAT - 1) begin
                        failures++;
                        $display("FAIL stream_latency: got edge %0d expected %0d", edge_cnt, b.e + LAT - 1);
                    end
                    got++;
                end
            end
            in_valid = (sent < 100);
            drive_rand();
            if (in_valid && in_ready) begin
                push_main();
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++; if (got !== 100) begin failures++; $display("FAIL stream_count: got %0d expected 100", got); end
    endtask

    task automatic test_backpressure();
        int          sent = 0;
        int          got  = 0;
        logic        stalled = 1'b0;
        logic [31:0] ps;
        logic        pc, po;
        res_t        ex;
        for (int c = 0; c < 400; c++) begin
            out_ready = (c >= 300) ? 1'b1 : 1'($urandom_range(0, 1));
            in_valid  = (c < 300) && ($urandom_range(0, 3) != 0);
            drive_rand();
            #1;
            checks++;
            if (in_ready !== (out_ready | !out_valid)) begin
                failures++;
                $display("FAIL bp_in_ready: got %b expected %b", in_ready, out_ready | !out_valid);
            end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || {out_sum, out_cout, out_ovf} !== {ps, pc, po}) begin
                    failures++;
                    $display("FAIL bp_hold: got %b %h/%b/%b expected 1 %h/%b/%b", out_valid, out_sum, out_cout, out_ovf, ps, pc, po);
                end
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL bp_extra: got result %h expected none", out_sum);
                end else begin
                    ex = model(q[0].a, q[0].b, q[0].cin, q[0].sub, W);
                    checks++;
                    if ({out_sum, out_cout, out_ovf} !== {ex.sum[W-1:0], ex.cout, ex.ovf}) begin
                        failures++;
                        $display("FAIL bp_data: got %h/%b/%b expected %h/%b/%b", out_sum, out_cout, out_ovf, ex.sum[W-1:0], ex.cout, ex.ovf);
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        got++;
                    end
                end
            end
            stalled = out_valid && !out_ready;
            ps = out_sum; pc = out_cout; po = out_ovf;
            if (in_valid && in_ready) begin
                push_main();
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (q.size() != 0 || got !== sent) begin
            failures++;
            $display("FAIL bp_count: got %0d results expected %0d", got, sent);
        end
    endtask

    task automatic test_reset_mid();
        int          lat = 0;
        int          nout = 0;
        logic [31:0] first_sum = '0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive_rand();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_fill: got %b expected 1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
        checks++; if (out_sum !== '0) begin failures++; $display("FAIL rstmid_sum: got %h expected 0", out_sum); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        rst_n = 1'b1;
        in_a = 32'h1; in_b = 32'h1; in_cin = 1'b0; in_sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (out_valid) begin
                nout++;
                if (nout == 1) begin
                    lat = c;
                    first_sum = out_sum;
                end
            end
            @(posedge clk);
            #1;
        end
        checks++; if (nout !== 1) begin failures++; $display("FAIL rstmid_count: got %0d expected 1", nout); end
        checks++; if (lat !== LAT) begin failures++; $display("FAIL rstmid_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (first_sum !== 32'h2) begin failures++; $display("FAIL rstmid_sum_after: got %h expected 00000002", first_sum); end
    endtask

    task automatic test_sweep();
        int    sw_w[3]   = '{16, 64, 8};
        int    sw_lat[3] = '{4, 4, 1};
        int    rd[3]     = '{0, 0, 0};
        logic  ov, rdy;
        res_t  got, ex;
        beat_t b;
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < 3; i++) begin
                case (i)
                    0:       begin ov = s0_ov; rdy = s0_rdy; got.sum = {48'b0, s0_sum}; got.cout = s0_co; got.ovf = s0_of; end
                    1:       begin ov = s1_ov; rdy = s1_rdy; got.sum = s1_sum;          got.cout = s1_co; got.ovf = s1_of; end
                    default: begin ov = s2_ov; rdy = s2_rdy; got.sum = {56'b0, s2_sum}; got.cout = s2_co; got.ovf = s2_of; end
                endcase
                checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL sweep%0d_in_ready: got %b expected 1", sw_w[i], rdy); end
                if (ov) begin
                    if (rd[i] >= sw_q.size()) begin
                        checks++; failures++;
                        $display("FAIL sweep%0d_extra: got %h expected none", sw_w[i], got.sum);
                    end else begin
                        b  = sw_q[rd[i]];
                        ex = model(b.a, b.b, b.cin, b.sub, sw_w[i]);
                        checks++;
                        if (got !== ex) begin
                            failures++;
                            $display("FAIL sweep%0d_data: got %h/%b/%b expected %h/%b/%b", sw_w[i], got.sum, got.cout, got.ovf, ex.sum, ex.cout, ex.ovf);
                        end
                        checks++;
                        if (edge_cnt !== b.e + sw_lat[i] - 1) begin
                            failures++;
                            $display("FAIL sweep%0d_latency: got edge %0d expected %0d", sw_w[i], edge_cnt, b.e + sw_lat[i] - 1);
                        end
                        rd[i]++;
                    end
                end
            end
            sw_valid = (c < 60) && ($urandom_range(0, 3) != 0);
            sw_a     = rnd_op();
            sw_b     = rnd_op();
            sw_cin   = 1'($urandom_range(0, 1));
            sw_sub   = 1'($urandom_range(0, 1));
            if (sw_valid) begin
                b.a = sw_a; b.b = sw_b; b.cin = sw_cin; b.sub = sw_sub; b.e = edge_cnt + 1;
                sw_q.push_back(b);
            end
            @(posedge clk);
            #1;
        end
        sw_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd[i] != sw_q.size()) begin
                failures++;
                $display("FAIL sweep%0d_count: got %0d expected %0d", sw_w[i], rd[i], sw_q.size());
            end
        end
    endtask

    initial begin
        #3 rst_n = 1'b0;
        test_reset();
        test_directed();
        test_stream();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
